// File: rtl/macrocell_reg.sv
// -----------------------------------------------------------------------------
// macrocell_reg
//
// Macrocell storage element at the receiving end of the clock/enable routing.
// It implements the macrocell flip-flop in D, T, JK or SR mode. All state is
// clocked from the single global clock. A product-term clock is modelled as a
// synchronised, rising-edge-detected update strobe. The block also keeps a
// saturating count of q transitions for simulation statistics.
//
// Parameters
//   CNT_W      width of the saturating q-transition counter
//
// Ports
//   gclk       global clock; all state updates on its rising edge
//   gclr_n     global clear, asynchronous, active-low
//   clk_sel    0: every gclk edge is a clock event, 1: ptclk rising edges only
//   ptclk      product-term clock request (level)
//   ffen       routed clock-enable; 1 = clock events are accepted
//   mode       00 D, 01 T, 10 JK, 11 SR
//   d          D / T / J / S data input
//   k          K / R data input (ignored in D and T modes)
//   ar         reset product term, synchronous, highest priority
//   ap         preset product term, synchronous, below ar
//   fb_bypass  1: fb carries d, 0: fb carries q
//   q          register output
//   fb         feedback mux output (combinational)
//   upd        one-cycle strobe after each accepted data load
//   tog_cnt    saturating count of q transitions
// -----------------------------------------------------------------------------
module macrocell_reg #(
    parameter int CNT_W = 8
) (
    input  logic             gclk,
    input  logic             gclr_n,
    input  logic             clk_sel,
    input  logic             ptclk,
    input  logic             ffen,
    input  logic [1:0]       mode,
    input  logic             d,
    input  logic             k,
    input  logic             ar,
    input  logic             ap,
    input  logic             fb_bypass,
    output logic             q,
    output logic             fb,
    output logic             upd,
    output logic [CNT_W-1:0] tog_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    // -------------------------------------------------------------------------
    // Product-term clock synchroniser and rising-edge detector.
    // ptclk_q is the first sample, ptclk_prev the one before it. A level held
    // high yields exactly one pt_event; falling edges produce nothing.
    // -------------------------------------------------------------------------
    logic ptclk_q;
    logic ptclk_prev;
    logic pt_event;

    assign pt_event = ptclk_q & ~ptclk_prev;

    // -------------------------------------------------------------------------
    // Clock event and load qualification. ar/ap take precedence over a data
    // load and ignore ffen and clk_sel entirely.
    // -------------------------------------------------------------------------
    logic clk_event;
    logic do_load;

    assign clk_event = clk_sel ? pt_event : 1'b1;
    assign do_load   = clk_event & ffen & ~ar & ~ap;

    // -------------------------------------------------------------------------
    // Data-load value for the selected flip-flop mode.
    // -------------------------------------------------------------------------
    logic load_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        load_val = q;
        unique case (mode_sel)
            MODE_D:  load_val = d;
            MODE_T:  load_val = q ^ d;
            MODE_JK: begin
                unique case ({d, k})
                    2'b00:   load_val = q;
                    2'b01:   load_val = 1'b0;
                    2'b10:   load_val = 1'b1;
                    default: load_val = ~q;
                endcase
            end
            MODE_SR: begin
                // Set only when S=1 and R=0; R wins when both are asserted.
                unique case ({d, k})
                    2'b00:   load_val = q;
                    2'b10:   load_val = 1'b1;
                    default: load_val = 1'b0;
                endcase
            end
            default: load_val = q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next q with the override priority: ar, then ap, then data load, else hold.
    // -------------------------------------------------------------------------
    logic q_next;

    always_comb begin
        q_next = q;
        if (ar) begin
            q_next = 1'b0;
        end else if (ap) begin
            q_next = 1'b1;
        end else if (do_load) begin
            q_next = load_val;
        end
    end

    // The counter counts every q change regardless of its cause and stops at
    // all-ones rather than wrapping.
    logic tog_sat;
    logic q_changes;

    assign tog_sat   = &tog_cnt;
    assign q_changes = q_next ^ q;

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge gclk or negedge gclr_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!gclr_n) begin
            ptclk_q    <= 1'b0;
            ptclk_prev <= 1'b0;
            q          <= 1'b0;
            upd        <= 1'b0;
            tog_cnt    <= '0;
        end else begin
            ptclk_q    <= ptclk;
            ptclk_prev <= ptclk_q;
            q          <= q_next;
            upd        <= do_load;
            if (q_changes && !tog_sat) begin
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
        end
    end

    // Feedback path is purely combinational.
    assign fb = fb_bypass ? d : q;

endmodule

// File: tb/tb_macrocell_reg.sv
// -----------------------------------------------------------------------------
// tb_macrocell_reg
//
// Self-checking bench for macrocell_reg. Two instances share all inputs: one
// with the default 8-bit counter and one with a 3-bit counter to reach
// saturation quickly. A behavioural reference model computes the expected
// state at every gclk edge; the expectation is queued when the stimulus is
// applied and popped and compared one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_macrocell_reg;

    logic       gclk;
    logic       gclr_n;
    logic       clk_sel;
    logic       ptclk;
    logic       ffen;
    logic [1:0] mode;
    logic       d;
    logic       k;
    logic       ar;
    logic       ap;
    logic       fb_bypass;

    logic       q8, fb8, upd8;
    logic [7:0] tog8;
    logic       q3, fb3, upd3;
    logic [2:0] tog3;

    macrocell_reg #(.CNT_W(8)) dut8 (
        .gclk(gclk), .gclr_n(gclr_n), .clk_sel(clk_sel), .ptclk(ptclk),
        .ffen(ffen), .mode(mode), .d(d), .k(k), .ar(ar), .ap(ap),
        .fb_bypass(fb_bypass), .q(q8), .fb(fb8), .upd(upd8), .tog_cnt(tog8)
    );

    macrocell_reg #(.CNT_W(3)) dut3 (
        .gclk(gclk), .gclr_n(gclr_n), .clk_sel(clk_sel), .ptclk(ptclk),
        .ffen(ffen), .mode(mode), .d(d), .k(k), .ar(ar), .ap(ap),
        .fb_bypass(fb_bypass), .q(q3), .fb(fb3), .upd(upd3), .tog_cnt(tog3)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        logic       q;
        logic       upd;
        logic [7:0] tog8;
        logic [2:0] tog3;
    } exp_t;

    exp_t sb_q[$];

    logic       m_q, m_upd, m_pq, m_pp;
    logic [7:0] m_tog8;
    logic [2:0] m_tog3;

    task automatic model_reset();
        m_q = 0; m_upd = 0; m_pq = 0; m_pp = 0; m_tog8 = 0; m_tog3 = 0;
        sb_q.delete();
    endtask

    // Advance the model by one gclk edge using the currently driven inputs.
    task automatic model_step();
        logic ev, nq, loaded;
        exp_t e;
        ev     = clk_sel ? (m_pq && !m_pp) : 1'b1;
        loaded = 1'b0;
        if (ar)      nq = 1'b0;
        else if (ap) nq = 1'b1;
        else if (ev && ffen) begin
            loaded = 1'b1;
            case (mode)
                2'd0: nq = d;
                2'd1: nq = d ? !m_q : m_q;
                2'd2: nq = (d && k) ? !m_q : (d ? 1'b1 : (k ? 1'b0 : m_q));
                default: nq = k ? 1'b0 : (d ? 1'b1 : m_q);
            endcase
        end else nq = m_q;
        if (nq != m_q) begin
            if (m_tog8 != 8'hFF) m_tog8 = m_tog8 + 8'd1;
            if (m_tog3 != 3'd7)  m_tog3 = m_tog3 + 3'd1;
        end
        m_q   = nq;
        m_upd = loaded;
        m_pp  = m_pq;
        m_pq  = ptclk;
        e.q = m_q; e.upd = m_upd; e.tog8 = m_tog8; e.tog3 = m_tog3;
        sb_q.push_back(e);
    endtask

    // One clock: queue the expectation, take the edge, compare off-edge.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge gclk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("q8",   {31'd0, q8},   {31'd0, e.q});
            check("q3",   {31'd0, q3},   {31'd0, e.q});
            check("upd8", {31'd0, upd8}, {31'd0, e.upd});
            check("upd3", {31'd0, upd3}, {31'd0, e.upd});
            check("tog8", {24'd0, tog8}, {24'd0, e.tog8});
            check("tog3", {29'd0, tog3}, {29'd0, e.tog3});
            check("fb8",  {31'd0, fb8},  {31'd0, fb_bypass ? d : e.q});
        end
    endtask

    task automatic async_clear();
        gclr_n = 1'b0;
        #2;
        check("clr_q",   {31'd0, q8},   0);
        check("clr_upd", {31'd0, upd8}, 0);
        check("clr_tog", {24'd0, tog8}, 0);
        model_reset();
        gclr_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin : main
        int cnt;
        logic [1:0] jk_v [5];
        logic       jk_e [5];

        gclr_n = 0; clk_sel = 0; ptclk = 0; ffen = 1; mode = 2'd0;
        d = 1; k = 0; ar = 0; ap = 0; fb_bypass = 0;
        model_reset();

        // Reset holds everything at zero even with d=1 and clock events.
        #3;
        check("rst_q",   {31'd0, q8},   0);
        check("rst_tog", {24'd0, tog8}, 0);
        @(posedge gclk); @(posedge gclk); #1;
        check("rst_hold_q", {31'd0, q8}, 0);
        gclr_n = 1;

        // D mode: q loads on the first edge, upd follows a cycle later.
        tick();
        check("d_load_q",   {31'd0, q8},   1);
        check("d_load_tog", {24'd0, tog8}, 1);
        tick();
        check("d_upd", {31'd0, upd8}, 1);
        d = 0;
        tick();

        // Product-term clock: 2-edge latency, one event for a held level.
        clk_sel = 1; d = 1; ptclk = 1;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) check("pt_lat1_q", {31'd0, q8}, 0);
            if (i == 2) check("pt_lat2_q", {31'd0, q8}, 1);
            if (upd8) cnt++;
        end
        check("pt_upd_pulses", cnt, 1);
        ptclk = 0; d = 0;
        tick(); tick();
        // Rising edge while ffen=0 is not accepted.
        ffen = 0; ptclk = 1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (upd8) cnt++;
        end
        check("pt_ffen0_q",   {31'd0, q8}, 1);
        check("pt_ffen0_upd", cnt, 0);
        ptclk = 0; ffen = 1;
        tick(); tick();

        // JK table from q=0.
        clk_sel = 0; ar = 1;
        tick();
        ar = 0; mode = 2'd2;
        jk_v = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        jk_e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            {d, k} = jk_v[i];
            tick();
            check($sformatf("jk%0d_q", i), {31'd0, q8}, {31'd0, jk_e[i]});
        end
        // SR with S=R=1 from q=1 resets.
        mode = 2'd3; d = 1; k = 1;
        tick();
        check("sr11_q", {31'd0, q8}, 0);
        // Mode change alone does not disturb q.
        ffen = 0; mode = 2'd1;
        tick();
        check("mode_chg_q", {31'd0, q8}, 0);

        // Override priority.
        ffen = 1; mode = 2'd0; d = 1; ar = 1; ap = 1;
        tick();
        check("arap_q",   {31'd0, q8},   0);
        check("arap_upd", {31'd0, upd8}, 0);
        ar = 0; ffen = 0;
        tick();
        check("ap_ffen0_q",   {31'd0, q8},   1);
        check("ap_ffen0_upd", {31'd0, upd8}, 0);
        ap = 0;
        async_clear();
        check("clr_mid_q", {31'd0, q8}, 0);

        // Counter saturation.
        ffen = 1; clk_sel = 0; mode = 2'd1; d = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("sat_tog3", {29'd0, tog3}, (i > 7) ? 7 : i);
            check("sat_tog8", {24'd0, tog8}, i);
        end

        // Pending ptclk edge is discarded by a clear.
        mode = 2'd0; clk_sel = 1; d = 1; ptclk = 1;
        tick();
        ptclk = 0;
        async_clear();
        tick(); tick();
        check("pt_discard_q", {31'd0, q8}, 0);

        // Feedback bypass follows d combinationally.
        fb_bypass = 1;
        for (int v = 0; v < 2; v++) begin
            d = v[0];
            #1;
            check("fb_bypass", {31'd0, fb8}, {31'd0, v[0]});
            check("fb_bypass3", {31'd0, fb3}, {31'd0, v[0]});
        end
        fb_bypass = 0;
        #1;
        check("fb_q", {31'd0, fb8}, {31'd0, m_q});

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            clk_sel   = $urandom_range(0, 1) == 1;
            ptclk     = $urandom_range(0, 2) != 0;
            ffen      = $urandom_range(0, 3) != 0;
            mode      = 2'($urandom_range(0, 3));
            d         = $urandom_range(0, 1) == 1;
            k         = $urandom_range(0, 1) == 1;
            ar        = $urandom_range(0, 15) == 0;
            ap        = $urandom_range(0, 15) == 0;
            fb_bypass = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/macrocell_reg.md
Name: macrocell_reg

Overview:
- Storage element at the receiving end of macrocell clock/enable routing.
- Consumes the routed clock-enable, a product-term clock request and the async-style reset/preset product terms.
- Implements the macrocell flip-flop in D, T, JK or SR mode.
- The simulator runs from one global clock, so a product-term clock is modelled as a synchronised edge-detected update strobe. The block also counts output transitions for simulation statistics.

Parameters:
- CNT_W, 8, width of the saturating q-transition counter.

Ports:
- gclk  input  1  global clock; all state updates on its rising edge.
- gclr_n  input  1  global clear; asynchronous, active-low.
- clk_sel  input  1  0 = every gclk edge is a clock event; 1 = product-term clock (ptclk) edges only.
- ptclk  input  1  product-term clock request, level signal.
- ffen  input  1  routed clock-enable; 1 = clock events are accepted.
- mode  input  2  00 D, 01 T, 10 JK, 11 SR.
- d  input  1  D / T / J / S data input.
- k  input  1  K / R data input; ignored in D and T modes.
- ar  input  1  reset product term; synchronous override.
- ap  input  1  preset product term; synchronous override.
- fb_bypass  input  1  1 = fb carries d; 0 = fb carries q.
- q  output  1  register output.
- fb  output  1  feedback mux output (combinational).
- upd  output  1  one-cycle strobe after each accepted data load.
- tog_cnt  output  CNT_W  saturating count of q transitions.

Behaviour:
- Reset: gclr_n low forces, immediately and asynchronously, q=0, upd=0, tog_cnt=0, ptclk_q=0, ptclk_prev=0. Reset mid-operation discards any pending ptclk edge. The first event after release is evaluated normally.
- Ptclk synchroniser: every gclk edge, ptclk_q<=ptclk and ptclk_prev<=ptclk_q.
  - pt_event = ptclk_q & ~ptclk_prev.
  - q loads on the second gclk edge after ptclk is first sampled high. Latency is 2 cycles from the ptclk rise.
  - A ptclk pulse shorter than one gclk period may be missed. Holding ptclk high produces exactly one event.
  - ptclk falling edges are ignored.
- Event: event = clk_sel ? pt_event : 1.
- Priority each gclk edge, highest first:
  1. ar=1 -> q<=0.
  2. ap=1 -> q<=1. With ar=ap=1, ar wins (q=0).
  3. event & ffen -> data load per mode.
  4. Otherwise q holds.
  - ar and ap ignore ffen and clk_sel.
- Data load by mode:
  - D: q<=d.
  - T: q<=q^d.
  - JK (J=d): 00 hold, 01 q<=0, 10 q<=1, 11 toggle.
  - SR (S=d): 00 hold, 10 q<=1, 01 q<=0, 11 q<=0 (reset dominant).
- Mode changes take effect at the next load; stored q is unaffected.
- upd: registered. It is 1 in the cycle after any data load, including loads that leave q unchanged, and 0 otherwise. It is never set by ar/ap loads. Back-to-back loads keep upd high continuously.
- tog_cnt: increments by 1 on every gclk edge where the next q differs from the current q, from any cause. It saturates at 2^CNT_W-1 and never wraps.
- fb = fb_bypass ? d : q, with no register.

Test Plan:
- Reset and D mode: gclr_n=0 with d=1 -> q=0, tog_cnt=0. Release, clk_sel=0, ffen=1, mode=00, d=1 -> q=1 after 1 edge, upd=1 next cycle, tog_cnt=1.
- Ptclk latency and level hold: clk_sel=1, D mode, d=1, ptclk raised and held 10 cycles -> q=1 exactly 2 edges after the rise, single upd pulse. ffen=0 during the rise -> q unchanged, no upd.
- JK/SR tables: step JK through 00, 01, 10, 11, 11 from q=0 -> q = 0, 0, 1, 0, 1. SR with 11 from q=1 -> q=0.
- Override priority: ar=ap=1 with ffen=1, d=1 -> q=0, upd=0. ap alone with ffen=0 -> q=1 on next edge. gclr_n pulsed low mid-cycle -> q=0 before the next gclk edge.
- Counter saturation: CNT_W=3, T mode, d=1 for 12 edges -> tog_cnt reads 1..7, then holds at 7. fb_bypass=1 -> fb follows d combinationally.
